fpu_core: RTL and testbench

FPU_CORE -- requirements
Module: fpu_core

---
 rtl/fpu_core.sv | 272 +++++++++++++++++++++++++++
 tb/tb_fpu_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_core.sv
// Small x87-style stack FPU: eight 80-bit registers addressed relative to TOP, four-state sequencer.
// Optional FPTAN support is compiled in when FPU_FPTAN_EN is defined.
module fpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        execute,
  input  logic [7:0]  instruction,
  input  logic [2:0]  stack_index,
  input  logic [79:0] data_in,
  input  logic [31:0] int_data_in,
  input  logic [15:0] control_in,
  input  logic        control_write,
  output logic        ready,
  output logic        error,
  output logic [79:0] data_out,
  output logic [15:0] status_out,
  output logic [1:0]  fsm_state
);

  // Handshake: execute is sampled on a rising edge only while ready=1 (idle);
  // ready then stays low until the instruction has fully retired.

  localparam logic [7:0] OP_FLD  = 8'h20;
  localparam logic [7:0] OP_FILD = 8'h21;
  localparam logic [7:0] OP_FLDZ = 8'h22;
  localparam logic [7:0] OP_FLD1 = 8'h23;
  localparam logic [7:0] OP_FST  = 8'h30;
  localparam logic [7:0] OP_FSTP = 8'h31;
  localparam logic [7:0] OP_FCHS = 8'h40;
  localparam logic [7:0] OP_FABS = 8'h41;
  localparam logic [7:0] OP_FXCH = 8'h42;
`ifdef FPU_FPTAN_EN
  localparam logic [7:0] OP_FPTAN = 8'h54;
`endif

  localparam logic [1:0] TAG_VALID = 2'b00;
  localparam logic [1:0] TAG_ZERO  = 2'b01;
  localparam logic [1:0] TAG_EMPTY = 2'b11;

  localparam logic [79:0] VAL_ONE   = 80'h3FFF_8000000000000000;
  localparam logic [79:0] VAL_INDEF = 80'hFFFF_C000000000000000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_STACK} state_t;

  typedef struct packed {
    logic        wa_en;
    logic [2:0]  wa_slot;
    logic [79:0] wa_val;
    logic [1:0]  wa_tag;
    logic        wb_en;
    logic [2:0]  wb_slot;
    logic [79:0] wb_val;
    logic [1:0]  wb_tag;
    logic        st_en;
    logic [79:0] st_val;
    logic        push;
    logic        pop;
    logic        ie_set;
    logic        sf_set;
    logic        c1_wr;
    logic        c1_val;
    logic        c2_wr;
    logic        c2_val;
  } pend_t;

  state_t      state;
  logic [79:0] regs [8];
  logic [1:0]  tags [8];
  logic [2:0]  top;
  logic [15:0] cw;
  logic        ie, sf, c1, c2;
  logic [7:0]  op_q;
  logic [2:0]  idx_q;
  logic [79:0] din_q;
  logic [31:0] idin_q;
  pend_t       pend, nxt;

  logic [2:0]  slot0, sloti, slotp;
  logic [79:0] push_val;
  logic [1:0]  push_tag;
  logic        uflow;
  logic [31:0] fild_mag, fild_sig;
  logic [4:0]  fild_msb;
  logic [79:0] fild_val;
  logic        es;
  logic        unused_cw;

  assign slot0 = top;
  assign sloti = top + idx_q;
  assign slotp = top - 3'd1;

  // Integer load is exact: normalise the magnitude so its MSB lands on the explicit integer bit.
  always_comb begin
    fild_mag = idin_q[31] ? (~idin_q + 32'd1) : idin_q;
    fild_msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (fild_mag[i]) fild_msb = 5'(i);
    end
    fild_sig = fild_mag << (5'd31 - fild_msb);
    fild_val = (fild_mag == 32'd0) ? 80'd0
             : {idin_q[31], 15'h3FFF + {10'd0, fild_msb}, fild_sig, 32'd0};
  end

  always_comb begin
    nxt      = '0;
    push_val = '0;
    push_tag = TAG_VALID;
    uflow    = 1'b0;
    case (op_q)
      OP_FLD: begin
        nxt.push = 1'b1;
        push_val = din_q;
        push_tag = (din_q[78:0] == 79'd0) ? TAG_ZERO : TAG_VALID;
      end
      OP_FILD: begin
        nxt.push = 1'b1;
        push_val = fild_val;
        push_tag = (fild_mag == 32'd0) ? TAG_ZERO : TAG_VALID;
      end
      OP_FLDZ: begin
        nxt.push = 1'b1;
        push_tag = TAG_ZERO;
      end
      OP_FLD1: begin
        nxt.push = 1'b1;
        push_val = VAL_ONE;
      end
      OP_FST, OP_FSTP: begin
        if (tags[sloti] == TAG_EMPTY) uflow = 1'b1;
        else begin
          nxt.st_en  = 1'b1;
          nxt.st_val = regs[sloti];
          nxt.pop    = (op_q == OP_FSTP);
        end
      end
      OP_FCHS, OP_FABS: begin
        if (tags[slot0] == TAG_EMPTY) uflow = 1'b1;
        else begin
          nxt.wa_en   = 1'b1;
          nxt.wa_slot = slot0;
          nxt.wa_val  = {(op_q == OP_FCHS) ? ~regs[slot0][79] : 1'b0, regs[slot0][78:0]};
          nxt.wa_tag  = tags[slot0];
        end
      end
      OP_FXCH: begin
        if (tags[slot0] == TAG_EMPTY || tags[sloti] == TAG_EMPTY) uflow = 1'b1;
        else begin
          nxt.wa_en   = 1'b1;
          nxt.wa_slot = slot0;
          nxt.wa_val  = regs[sloti];
          nxt.wa_tag  = tags[sloti];
          nxt.wb_en   = 1'b1;
          nxt.wb_slot = sloti;
          nxt.wb_val  = regs[slot0];
          nxt.wb_tag  = tags[slot0];
        end
      end
`ifdef FPU_FPTAN_EN
      OP_FPTAN: begin
        if (tags[slot0] == TAG_EMPTY) uflow = 1'b1;
        else if (tags[slot0] == TAG_ZERO) begin
          // tan(+-0) = +-0, so ST(0) stays and 1.0 is pushed on top of it.
          nxt.push   = 1'b1;
          push_val   = VAL_ONE;
          nxt.c2_wr  = 1'b1;
          nxt.c2_val = 1'b0;
        end else begin
          nxt.c2_wr  = 1'b1;
          nxt.c2_val = 1'b1;
        end
      end
`endif
      default: nxt.ie_set = 1'b1;
    endcase

    if (nxt.push) begin
      nxt.wa_en   = 1'b1;
      nxt.wa_slot = slotp;
      if (tags[slotp] != TAG_EMPTY) begin
        nxt.wa_val = VAL_INDEF;
        nxt.wa_tag = TAG_VALID;
        nxt.ie_set = 1'b1;
        nxt.sf_set = 1'b1;
        nxt.c1_wr  = 1'b1;
        nxt.c1_val = 1'b1;
      end else begin
        nxt.wa_val = push_val;
        nxt.wa_tag = push_tag;
      end
    end
    if (uflow) begin
      nxt.ie_set = 1'b1;
      nxt.sf_set = 1'b1;
      nxt.c1_wr  = 1'b1;
      nxt.c1_val = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      top      <= 3'd0;
      cw       <= 16'h037F;
      ie       <= 1'b0;
      sf       <= 1'b0;
      c1       <= 1'b0;
      c2       <= 1'b0;
      data_out <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      din_q    <= '0;
      idin_q   <= '0;
      pend     <= '0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
        tags[i] <= TAG_EMPTY;
      end
    end else begin
      if (control_write) cw <= control_in;
      case (state)
        S_IDLE: begin
          if (!ready) ready <= 1'b1;
          else if (execute) begin
            op_q   <= instruction;
            idx_q  <= stack_index;
            din_q  <= data_in;
            idin_q <= int_data_in;
            ready  <= 1'b0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          pend  <= nxt;
          state <= S_WB;
        end
        S_WB: begin
          if (pend.wb_en) begin
            regs[pend.wb_slot] <= pend.wb_val;
            tags[pend.wb_slot] <= pend.wb_tag;
          end
          if (pend.wa_en) begin
            regs[pend.wa_slot] <= pend.wa_val;
            tags[pend.wa_slot] <= pend.wa_tag;
          end
          if (pend.st_en)  data_out <= pend.st_val;
          if (pend.ie_set) ie <= 1'b1;
          if (pend.sf_set) sf <= 1'b1;
          if (pend.c1_wr)  c1 <= pend.c1_val;
          if (pend.c2_wr)  c2 <= pend.c2_val;
          state <= S_STACK;
        end
        S_STACK: begin
          if (pend.push) top <= top - 3'd1;
          else if (pend.pop) begin
            tags[top] <= TAG_EMPTY;
            top       <= top + 3'd1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign es         = ie & ~cw[0];
  assign error      = es;
  assign status_out = {~ready, 1'b0, top, c2, c1, 1'b0, es, sf, 5'b0, ie};
  assign fsm_state  = state;
  assign unused_cw  = ^cw[15:1];

endmodule

// File: tb/tb_fpu_core.sv
// Scoreboard bench for fpu_core: expected {data_out, status_out} is queued per instruction
// and checked by a monitor whenever the core returns to ready.
module tb_fpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        execute = 1'b0;
  logic [7:0]  instruction = '0;
  logic [2:0]  stack_index = '0;
  logic [79:0] data_in = '0;
  logic [31:0] int_data_in = '0;
  logic [15:0] control_in = '0;
  logic        control_write = 1'b0;
  logic        ready, error;
  logic [79:0] data_out;
  logic [15:0] status_out;
  logic [1:0]  fsm_state;

  localparam logic [7:0] FLD = 8'h20, FILD = 8'h21, FLD1 = 8'h23;
  localparam logic [7:0] FST = 8'h30, FSTP = 8'h31, FCHS = 8'h40, FABS = 8'h41;
  localparam logic [7:0] FXCH = 8'h42, FPTAN = 8'h54, BAD = 8'h99;
  localparam logic [79:0] ONE   = 80'h3FFF_8000000000000000;
  localparam logic [79:0] TWO   = 80'h4000_8000000000000000;
  localparam logic [79:0] INDEF = 80'hFFFF_C000000000000000;
  localparam logic [79:0] NEG5  = 80'hC001_A000000000000000;
  localparam logic [79:0] MININT = 80'hC01E_8000000000000000;
  localparam logic [79:0] MAXINT = 80'h401D_FFFFFFFE00000000;
  localparam logic [79:0] NMAXINT = 80'hC01D_FFFFFFFE00000000;

  fpu_core dut (
    .clk(clk), .reset(reset), .execute(execute), .instruction(instruction),
    .stack_index(stack_index), .data_in(data_in), .int_data_in(int_data_in),
    .control_in(control_in), .control_write(control_write), .ready(ready),
    .error(error), .data_out(data_out), .status_out(status_out), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [95:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_ready = 1'b1;

  function automatic logic [15:0] sw(input logic [2:0] top, input logic c2, input logic c1,
                                     input logic es, input logic sf, input logic ie);
    return {1'b0, 1'b0, top, c2, c1, 1'b0, es, sf, 5'b0, ie};
  endfunction

  // monitor: a rising ready marks a retired (or reset-aborted) instruction
  always @(negedge clk) begin
    logic [95:0] e;
    string       nm;
    if (ready && !prev_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_completion: data_out=%h status=%h, no result was expected",
                 data_out, status_out);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({data_out, status_out} !== e) begin
          n_err++;
          $display("FAIL %s: data_out=%h status=%h, required data_out=%h status=%h",
                   nm, data_out, status_out, e[95:16], e[15:0]);
        end
      end
    end
    prev_ready = ready;
  end

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", ready, k);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [2:0] idx, input logic [79:0] din,
                       input logic [31:0] idin, input logic [79:0] exp_d, input logic [15:0] exp_s,
                       input string nm);
    wait_ready();
    instruction = op;
    stack_index = idx;
    data_in     = din;
    int_data_in = idin;
    execute     = 1'b1;
    exp_q.push_back({exp_d, exp_s});
    name_q.push_back(nm);
    @(posedge clk);
    #1 execute = 1'b0;
  endtask

  task automatic do_reset();
    wait_ready();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic write_cw(input logic [15:0] v);
    @(negedge clk);
    control_in    = v;
    control_write = 1'b1;
    @(negedge clk);
    control_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready_error", {94'd0, ready, error}, {94'd0, 1'b1, 1'b0});
    check("reset_outputs", {data_out, status_out}, 96'd0);
    reset = 1'b1;

    // integer loads, stores, sign ops, exchange, pop
    issue(FILD, 0, 0, -32'sd5,      0,       sw(7,0,0,0,0,0), "fild_neg5");
    issue(FST,  0, 0, 0,            NEG5,    sw(7,0,0,0,0,0), "fst_neg5");
    issue(FILD, 0, 0, 0,            NEG5,    sw(6,0,0,0,0,0), "fild_zero");
    issue(FST,  0, 0, 0,            0,       sw(6,0,0,0,0,0), "fst_zero");
    issue(FILD, 0, 0, 32'h80000000, 0,       sw(5,0,0,0,0,0), "fild_minint");
    issue(FST,  0, 0, 0,            MININT,  sw(5,0,0,0,0,0), "fst_minint");
    issue(FILD, 0, 0, 32'h7FFFFFFF, MININT,  sw(4,0,0,0,0,0), "fild_maxint");
    issue(FST,  0, 0, 0,            MAXINT,  sw(4,0,0,0,0,0), "fst_maxint");
    issue(FST,  3, 0, 0,            NEG5,    sw(4,0,0,0,0,0), "fst_st3");
    issue(FCHS, 0, 0, 0,            NEG5,    sw(4,0,0,0,0,0), "fchs");
    issue(FST,  0, 0, 0,            NMAXINT, sw(4,0,0,0,0,0), "fst_after_fchs");
    issue(FABS, 0, 0, 0,            NMAXINT, sw(4,0,0,0,0,0), "fabs");
    issue(FST,  0, 0, 0,            MAXINT,  sw(4,0,0,0,0,0), "fst_after_fabs");
    issue(FXCH, 1, 0, 0,            MAXINT,  sw(4,0,0,0,0,0), "fxch_st1");
    issue(FST,  0, 0, 0,            MININT,  sw(4,0,0,0,0,0), "fst_st0_after_fxch");
    issue(FST,  1, 0, 0,            MAXINT,  sw(4,0,0,0,0,0), "fst_st1_after_fxch");
    issue(FSTP, 0, 0, 0,            MININT,  sw(5,0,0,0,0,0), "fstp");
    issue(FST,  0, 0, 0,            MAXINT,  sw(5,0,0,0,0,0), "fst_after_pop");
    issue(FILD, 0, 0, 32'd1,        MAXINT,  sw(4,0,0,0,0,0), "fild_one");
    issue(FST,  0, 0, 0,            ONE,     sw(4,0,0,0,0,0), "fst_one");

    // stack overflow with IE unmasked
    do_reset();
    write_cw(16'h037E);
    for (int i = 0; i < 8; i++)
      issue(FLD1, 0, 0, 0, 0, sw(3'(7 - i),0,0,0,0,0), "fld1_fill");
    issue(FLD1, 0, 0, 0, 0,     sw(7,0,1,1,1,1), "fld1_overflow");
    issue(FST,  0, 0, 0, INDEF, sw(7,0,1,1,1,1), "fst_indefinite");
    issue(FST,  1, 0, 0, ONE,   sw(7,0,1,1,1,1), "fst_st1_overflow");
    wait_ready();
    check("error_unmasked", {95'd0, error}, {95'd0, 1'b1});
    write_cw(16'h037F);
    check("error_masked", {95'd0, error}, 96'd0);

    // underflow and undefined opcode
    do_reset();
    issue(FST,  0, 0, 0, 0, sw(0,0,0,0,1,1), "fst_empty");
    issue(FCHS, 0, 0, 0, 0, sw(0,0,0,0,1,1), "fchs_empty");
    do_reset();
    issue(BAD,  0, 0, 0, 0, sw(0,0,0,0,0,1), "undefined_op");
    do_reset();
    issue(FLD1, 0, 0, 0, 0,   sw(7,0,0,0,0,0), "fld1_single");
    issue(FST,  3, 0, 0, 0,   sw(7,0,0,0,1,1), "fst_empty_st3");
    issue(FSTP, 0, 0, 0, ONE, sw(0,0,0,0,1,1), "fstp_last");
    issue(FST,  0, 0, 0, ONE, sw(0,0,0,0,1,1), "fst_after_last_pop");

    // partial tangent
    do_reset();
    issue(FLD, 0, 80'd0, 0, 0, sw(7,0,0,0,0,0), "fld_zero");
`ifdef FPU_FPTAN_EN
    issue(FPTAN, 0, 0, 0, 0,   sw(6,0,0,0,0,0), "fptan_zero");
    issue(FST,   0, 0, 0, ONE, sw(6,0,0,0,0,0), "fptan_zero_st0");
    issue(FST,   1, 0, 0, 0,   sw(6,0,0,0,0,0), "fptan_zero_st1");
    wait_ready();
    check("fptan_zero_error", {95'd0, error}, 96'd0);
`else
    issue(FPTAN, 0, 0, 0, 0,   sw(7,0,0,0,0,1), "fptan_undefined");
`endif
    do_reset();
    issue(FLD, 0, TWO, 0, 0, sw(7,0,0,0,0,0), "fld_two");
`ifdef FPU_FPTAN_EN
    issue(FPTAN, 0, 0,     0, 0,   sw(7,1,0,0,0,0), "fptan_nonzero");
    issue(FST,   0, 0,     0, TWO, sw(7,1,0,0,0,0), "fptan_nonzero_st0");
    issue(FLD,   0, 80'd0, 0, TWO, sw(6,1,0,0,0,0), "fld_zero_2");
    issue(FPTAN, 0, 0,     0, TWO, sw(5,0,0,0,0,0), "fptan_clears_c2");
    issue(FST,   0, 0,     0, ONE, sw(5,0,0,0,0,0), "fptan_push_st0");
`else
    issue(FPTAN, 0, 0, 0, 0,   sw(7,0,0,0,0,1), "fptan_undefined_2");
    issue(FST,   0, 0, 0, TWO, sw(7,0,0,0,0,1), "fst_two");
`endif

    // execute held through busy cycles: one instruction, ready back after 4 edges
    do_reset();
    wait_ready();
    instruction = FLD1;
    stack_index = 0;
    execute     = 1'b1;
    exp_q.push_back({80'd0, sw(7,0,0,0,0,0)});
    name_q.push_back("fld1_held_execute");
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ready_busy", {95'd0, ready}, 96'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check("ready_after_4", {95'd0, ready}, {95'd0, 1'b1});
    execute = 1'b0;
    issue(FST, 0, 0, 0, ONE, sw(7,0,0,0,0,0), "fst_after_held");

    // reset during EXECUTE aborts without touching the stack
    do_reset();
    wait_ready();
    instruction = FLD;
    data_in     = TWO;
    execute     = 1'b1;
    exp_q.push_back(96'd0);
    name_q.push_back("abort_by_reset");
    @(posedge clk);
    #1 execute = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_outputs", {data_out, status_out}, 96'd0);
    check("abort_ready", {95'd0, ready}, {95'd0, 1'b1});
    reset = 1'b1;
    issue(FST, 0, 0, 0, 0, sw(0,0,0,0,1,1), "fst_after_abort");

    wait_ready();
    repeat (2) @(negedge clk);
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
